// File: rtl/ofs_plat_utils_ccip_bmask_to_ranges.sv
// Splits a 64-byte write mask into ascending contiguous (start, length) byte ranges, one per cycle.
// Define OFS_PLAT_CCIP_BMASK_EMPTY_PASS_EN to emit a (0, 0, last) range for an all-zero mask.
module ofs_plat_utils_ccip_bmask_to_ranges #(
  parameter int unsigned TagWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [63:0]         in_bmask_i,
  input  logic [TagWidth-1:0] in_tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [5:0]          out_byte_start_o,
  output logic [6:0]          out_byte_len_o,
  output logic                out_last_o,
  output logic [TagWidth-1:0] out_tag_o
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                state_q, state_d;
  logic [63:0]           rem_q, rem_d;
  logic [5:0]            start_q, start_d;
  logic [6:0]            len_q, len_d;
  logic                  last_q, last_d;
  logic [TagWidth-1:0]   tag_q, tag_d;

  logic [63:0] ext_src, ext_shifted, ext_run_mask, ext_rem;
  logic [5:0]  ext_start;
  logic [6:0]  ext_len;
  logic        ext_found, ext_run;

  // Single extractor: the remainder while a request is mid-flight, otherwise the incoming mask.
  always_comb begin
    ext_src   = (state_q == StEmit && !last_q) ? rem_q : in_bmask_i;
    ext_start = '0;
    ext_found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!ext_found && ext_src[i]) begin
        ext_found = 1'b1;
        ext_start = 6'(i);
      end
    end
    ext_shifted = ext_src >> ext_start;
    ext_len     = '0;
    ext_run     = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (!ext_shifted[i]) ext_run = 1'b0;
      if (ext_run) ext_len = ext_len + 7'd1;
    end
    ext_run_mask = 64'((65'd1 << ext_len) - 65'd1) << ext_start;
    ext_rem      = ext_src & ~ext_run_mask;
  end

  logic accept, advance;

  always_comb begin
    in_ready_o = (state_q == StIdle) || (out_ready_i && last_q);
    accept     = in_valid_i && in_ready_o;
    advance    = (state_q == StEmit) && out_ready_i && !last_q;

    state_d = state_q;
    rem_d   = rem_q;
    start_d = start_q;
    len_d   = len_q;
    last_d  = last_q;
    tag_d   = tag_q;

    if (advance) begin
      rem_d   = ext_rem;
      start_d = ext_start;
      len_d   = ext_len;
      last_d  = (ext_rem == '0);
    end else if (accept) begin
`ifdef OFS_PLAT_CCIP_BMASK_EMPTY_PASS_EN
      // An empty mask extracts naturally to start 0, len 0, last 1.
      state_d = StEmit;
      rem_d   = ext_rem;
      start_d = ext_start;
      len_d   = ext_len;
      last_d  = (ext_rem == '0);
      tag_d   = in_tag_i;
`else
      if (in_bmask_i != '0) begin
        state_d = StEmit;
        rem_d   = ext_rem;
        start_d = ext_start;
        len_d   = ext_len;
        last_d  = (ext_rem == '0);
        tag_d   = in_tag_i;
      end else begin
        state_d = StIdle;
      end
`endif
    end else if (state_q == StEmit && out_ready_i && last_q) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rem_q   <= '0;
      start_q <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      start_q <= start_d;
      len_q   <= len_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid_o      = (state_q == StEmit);
  assign out_byte_start_o = start_q;
  assign out_byte_len_o   = len_q;
  assign out_last_o       = last_q;
  assign out_tag_o        = tag_q;

endmodule

// File: tb/tb_ofs_plat_utils_ccip_bmask_to_ranges.sv
// Randomized bench for ofs_plat_utils_ccip_bmask_to_ranges against a run-list reference model.
module tb_ofs_plat_utils_ccip_bmask_to_ranges;

  typedef struct packed {
    logic [5:0]  start;
    logic [6:0]  len;
    logic        last;
    logic [15:0] tag;
  } range_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_bmask_i = '0;
  logic [15:0] in_tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [5:0]  out_byte_start_o;
  logic [6:0]  out_byte_len_o;
  logic        out_last_o;
  logic [15:0] out_tag_o;

  int n_cmp = 0;
  int n_bad = 0;
  range_t exp_q[$];
  logic [63:0] dir_masks[$];

  ofs_plat_utils_ccip_bmask_to_ranges #(.TagWidth(16)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_bmask_i       (in_bmask_i),
    .in_tag_i         (in_tag_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_byte_start_o (out_byte_start_o),
    .out_byte_len_o   (out_byte_len_o),
    .out_last_o       (out_last_o),
    .out_tag_o        (out_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: every maximal run of ones is one range, in ascending order.
  task automatic model_push(input logic [63:0] m, input logic [15:0] tag);
    range_t r;
    int first = exp_q.size();
    int i = 0;
    while (i < 64) begin
      if (m[i]) begin
        r.start = 6'(i);
        r.len   = 0;
        while (i < 64 && m[i]) begin
          r.len = r.len + 1;
          i++;
        end
        r.last = 1'b0;
        r.tag  = tag;
        exp_q.push_back(r);
      end else begin
        i++;
      end
    end
    if (exp_q.size() > first) begin
      exp_q[exp_q.size()-1].last = 1'b1;
    end else begin
`ifdef OFS_PLAT_CCIP_BMASK_EMPTY_PASS_EN
      r = '{start: 6'd0, len: 7'd0, last: 1'b1, tag: tag};
      exp_q.push_back(r);
`endif
    end
  endtask

  // Called mid-cycle after inputs settle: checks outputs, then applies the coming edge's handshakes.
  task automatic cycle_check();
    logic exp_ready;
    check_eq("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
    exp_ready = (exp_q.size() == 0) || (out_ready_i && exp_q.size() == 1 && exp_q[0].last);
    check_eq("in_ready", 64'(in_ready_o), 64'(exp_ready));
    if (out_valid_o && exp_q.size() != 0) begin
      check_eq("range", 64'({out_byte_start_o, out_byte_len_o, out_last_o, out_tag_o}),
               64'(exp_q[0]));
    end
    if (out_valid_o && out_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
    if (in_valid_i && in_ready_o) model_push(in_bmask_i, in_tag_i);
  endtask

  function automatic logic [63:0] rand_mask();
    logic [63:0] m;
    int lo, hi;
    case ($urandom_range(0, 5))
      0: m = {$urandom(), $urandom()};
      1: m = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
      2: m = '0;
      3: m = '1;
      4: begin
        lo = $urandom_range(0, 63);
        hi = $urandom_range(lo, 63);
        m  = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      end
      default: m = 64'(1) << $urandom_range(0, 63);
    endcase
    return m;
  endfunction

  initial begin
    int pending;
    int stall_mode;
    int cyc;

    dir_masks = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_F00F, 64'h5555_5555_5555_5555,
                  64'h8000_0000_0000_0000, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0000,
                  64'h0000_0000_0000_0011, 64'h00FF_0000_FF00_00FF};

    #12;
    check_eq("rst_out_valid", 64'(out_valid_o), 64'd0);
    check_eq("rst_out_last", 64'(out_last_o), 64'd0);
    check_eq("rst_start", 64'(out_byte_start_o), 64'd0);
    check_eq("rst_len", 64'(out_byte_len_o), 64'd0);
    check_eq("rst_tag", 64'(out_tag_o), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed masks back to back with out_ready high, then random traffic with random stalls.
    pending = 0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_i);
      stall_mode = (cyc < 200) ? 0 : (cyc / 500) % 3;
      if (!pending) begin
        if (dir_masks.size() != 0) begin
          in_valid_i = 1'b1;
          in_bmask_i = dir_masks.pop_front();
          in_tag_i   = (cyc == 0) ? 16'h0012 : 16'($urandom());
          pending    = 1;
        end else if (cyc >= 200 && $urandom_range(0, 3) != 0) begin
          in_valid_i = 1'b1;
          in_bmask_i = rand_mask();
          in_tag_i   = 16'($urandom());
          pending    = 1;
        end else begin
          in_valid_i = 1'b0;
          in_bmask_i = {$urandom(), $urandom()};
        end
      end
      out_ready_i = (stall_mode == 0) ? 1'b1 : 1'($urandom_range(0, stall_mode) != 0);
      #1;
      if (in_valid_i && in_ready_o) pending = 0;
      cycle_check();
    end

    // Drain within a bounded number of cycles.
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      #1;
      cycle_check();
      @(negedge clk_i);
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset after the first range of a multi-range request.
    in_valid_i  = 1'b1;
    in_bmask_i  = 64'h00FF_0000_FF00_00FF;
    in_tag_i    = 16'hBEEF;
    out_ready_i = 1'b0;
    #1;
    cycle_check();
    @(negedge clk_i);
    in_valid_i = 1'b0;
    pending    = 1;
    for (int i = 0; i < 50 && pending; i++) begin
      out_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (out_valid_o && out_ready_i) pending = 0;
      cycle_check();
      @(negedge clk_i);
    end
    check_eq("first_range_taken", 64'(pending), 64'd0);
    out_ready_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(out_valid_o), 64'd0);
    check_eq("async_rst_start", 64'(out_byte_start_o), 64'd0);
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      #1;
      cycle_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ofs_plat_utils_ccip_bmask_to_ranges.md
# ofs_plat_utils_ccip_bmask_to_ranges

Splits a line-wide byte-write mask into the ordered sequence of contiguous CCI-P byte ranges (start, length) that cover exactly the enabled bytes. It is the inverse of the range-to-mask decode used on the Avalon/AXI side. It sits in the shim path where AXI/Avalon byte-masked writes must be issued to a CCI-P host channel as one or more partial-line writes. The block is a registered, valid/ready stream splitter that emits one range per cycle.

## Interface
- TAG_WIDTH, 16, width of opaque per-request tag carried to every emitted range.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_bmask  in  CCIP_CLDATA_BYTE_WIDTH (64)  byte-enable mask; bit i = byte i.
- in_tag  in  TAG_WIDTH  request tag.
- out_valid  out  1  range valid.
- out_ready  in  1  range consumed when out_valid & out_ready.
- out_byte_start  out  t_ccip_clByteIdx (6)  first byte of range.
- out_byte_len  out  7  bytes in range, 1..64 (0 only for empty-mask pass-through).
- out_last  out  1  final range of current request.
- out_tag  out  TAG_WIDTH  copy of in_tag.

## Operation
- States: IDLE (no range held), EMIT (out_valid=1, remaining mask register rem may be nonzero).
- Range extraction from mask m: start = index of lowest set bit; len = count of consecutive 1s from start upward (stops at first 0 or bit 63); next rem = m with bits [start, start+len-1] cleared; last = (next rem == 0).
- Accept in IDLE: load output registers from in_bmask extraction, rem <= next rem, tag latched, go EMIT.
- EMIT with out_ready & !out_last: extract next range from rem; stay EMIT.
- EMIT with out_ready & out_last: if in_valid, accept new request same cycle (back-to-back, stay EMIT); else go IDLE.
- in_ready = !out_valid | (out_ready & out_last); combinational on out_ready.
- Ranges emitted in ascending byte order, never overlapping, never adjacent (adjacent runs always merged).
- Full mask -> single range start 0, len 64, last 1. Worst case 0x5555…: 32 ranges.
- Zero mask: see Configuration.
- out_* stable while out_valid & !out_ready.

## Timing
- Reset values: out_valid 0, out_last 0, out_byte_start 0, out_byte_len 0, out_tag 0, rem 0, state IDLE; in_ready 1 after reset.
- Latency: accept at cycle N -> first range valid at N+1.
- Throughput: one range per cycle with out_ready held high; zero bubble between last range of one request and first of next.
- Request of k ranges occupies output for k cycles minimum.
- Reset asserted mid-request: all pending ranges discarded, outputs to reset values immediately (async); no partial replay after release.
- Extraction logic is one combinational level (priority encode + run length) feeding registers; no combinational path from in_* to out_*.

## Configuration
- OFS_PLAT_CCIP_BMASK_EMPTY_PASS_EN defined: zero in_bmask is accepted and produces one range start 0, len 0, last 1, with tag (keeps request/response counting 1:1).
- Undefined: zero in_bmask is accepted (in_ready as normal) and silently dropped; no output, state remains/returns IDLE.

## Test plan
- in_bmask all-ones, tag 0x12 -> one range (0, 64, last=1, tag 0x12) one cycle after accept.
- in_bmask 0x0000_0000_0000_F00F -> (0,4,last 0) then (12,4,last 1).
- in_bmask 0x5555_5555_5555_5555 with out_ready=1 -> 32 consecutive ranges start 0,2,…,62, len 1, last only on 62; in_ready low throughout except final cycle.
- in_bmask 0x8000_0000_0000_0000 then back-to-back 0x0000_0000_0000_00F0 -> (63,1,last) immediately followed next cycle by (4,4,last), no bubble.
- out_ready toggled randomly during 0x00FF_0000_FF00_00FF -> ranges (0,8),(24,8),(48,8) held stable under stall, order preserved; reset_n pulsed after first range -> out_valid 0 instantly, no further ranges.
- in_bmask 0: with macro -> (0,0,last 1); without macro -> no out_valid, next request processed normally.
